regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Register-file writeback arbiter with a pending-write scoreboard.
//   - Tracks one busy bit per architectural register (r0 never busy).
//   - Stalls issue on a write-after-write to a busy register.
//   - Round-robin arbitrates ALU and load writebacks onto one write port.
//   - Registers the granted write (1-cycle latency) with a byte mask.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   issue_valid/issue_rd/issue_ready decode issue handshake
//   alu_valid/alu_rd/alu_data/alu_ready         ALU writeback request
//   ld_valid/ld_rd/ld_data/ld_opcode/ld_ready   load writeback request
//   q_rs/q_rt/hazard                 hazard query
//   reg_we/reg_waddr/reg_wdata/reg_wmask        registered write port
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        issue_ready,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    input  logic [5:0]  ld_opcode,
    output logic        ld_ready,
    input  logic [4:0]  q_rs,
    input  logic [4:0]  q_rt,
    output logic        hazard,
    output logic        reg_we,
    output logic [4:0]  reg_waddr,
    output logic [31:0] reg_wdata,
    output logic [3:0]  reg_wmask
);

    localparam logic LG_ALU = 1'b0;
    localparam logic LG_LD  = 1'b1;

    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;

    logic [31:0] busy_q, busy_d;
    logic        last_grant_q, last_grant_d;
    logic        reg_we_q, reg_we_d;
    logic [4:0]  reg_waddr_q, reg_waddr_d;
    logic [31:0] reg_wdata_q, reg_wdata_d;
    logic [3:0]  reg_wmask_q, reg_wmask_d;

    logic [3:0]  ld_mask;

    // Ready outputs are forced low during reset so requests are dropped.
    always_comb begin
        issue_ready = 1'b0;
        alu_ready   = 1'b0;
        ld_ready    = 1'b0;
        if (!rst) begin
            issue_ready = issue_valid && ((issue_rd == 5'd0) || !busy_q[issue_rd]);
            // On contention the side not granted last wins.
            alu_ready   = alu_valid && (!ld_valid || (last_grant_q == LG_LD));
            ld_ready    = ld_valid && (!alu_valid || (last_grant_q == LG_ALU));
        end
    end

    assign hazard = busy_q[q_rs] | busy_q[q_rt];

    always_comb begin
        ld_mask = 4'b1111;
        if (ld_opcode == OP_LBU)
            ld_mask = 4'b0001;
        else if (ld_opcode == OP_LHU)
            ld_mask = 4'b0011;
    end

    always_comb begin
        busy_d       = busy_q;
        last_grant_d = last_grant_q;
        reg_we_d     = 1'b0;
        reg_waddr_d  = reg_waddr_q;
        reg_wdata_d  = reg_wdata_q;
        reg_wmask_d  = reg_wmask_q;

        if (alu_ready) begin
            reg_we_d         = (alu_rd != 5'd0);
            reg_waddr_d      = alu_rd;
            reg_wdata_d      = alu_data;
            reg_wmask_d      = 4'b1111;
            busy_d[alu_rd]   = 1'b0;
            last_grant_d     = LG_ALU;
        end else if (ld_ready) begin
            reg_we_d         = (ld_rd != 5'd0);
            reg_waddr_d      = ld_rd;
            reg_wdata_d      = ld_data;
            reg_wmask_d      = ld_mask;
            busy_d[ld_rd]    = 1'b0;
            last_grant_d     = LG_LD;
        end

        // Set is applied after clear so a same-cycle issue wins.
        if (issue_ready && (issue_rd != 5'd0))
            busy_d[issue_rd] = 1'b1;

        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= '0;
            last_grant_q <= LG_ALU;
            reg_we_q     <= 1'b0;
            reg_waddr_q  <= '0;
            reg_wdata_q  <= '0;
            reg_wmask_q  <= '0;
        end else begin
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
            reg_we_q     <= reg_we_d;
            reg_waddr_q  <= reg_waddr_d;
            reg_wdata_q  <= reg_wdata_d;
            reg_wmask_q  <= reg_wmask_d;
        end
    end

    assign reg_we    = reg_we_q;
    assign reg_waddr = reg_waddr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_wmask = reg_wmask_q;

endmodule
